crono59m_down: RTL and testbench
================================

Name: crono59m_down

Overview:
- Count-down companion to the 59:59 stopwatch: loads an MM:SS value in BCD, then decrements once per second to 00:00.
- Start/pause is toggled by `ctrl`; at 00:00 it stops and flags completion.
- Digit outputs use the same format as the stopwatch (um, dm, us, ds), so both blocks share one display path.

Parameters:
- CLK_DIV, default 1: clk cycles per one-second decrement; legal range 1..2^24. The value 1 decrements every RUN cycle, as for simulation.
- ALARM_LEN, default 8: width of the alarm pulse in clk cycles; used only with ALARM_EN.

Ports:
- clk      input   1  single clock, rising edge.
- rst      input   1  reset, asynchronous, active-high.
- ld       input   1  load strobe; captures ld_dm/ld_um/ld_ds/ld_us.
- ld_dm    input   4  load value, tens of minutes (0..5).
- ld_um    input   4  load value, units of minutes (0..9).
- ld_ds    input   4  load value, tens of seconds (0..5).
- ld_us    input   4  load value, units of seconds (0..9).
- ctrl     input   1  start/pause toggle, sampled every edge (level, one-cycle pulse expected).
- dm,um,ds,us  output  4 each  current BCD count.
- running  output  1  high while state is RUN.
- done     output  1  high while state is DONE.
- alarm    output  1  present only with ALARM_EN.

Behaviour:
- Interface fixed: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset clears all of the following immediately: state=IDLE, digits=0, prescaler=0, running=0, done=0, alarm=0.
- States: IDLE, RUN, PAUSE, DONE. All outputs are registered.
- ld in IDLE, PAUSE or DONE:
  - Captures all four digits, clears the prescaler, and sets state=IDLE on the same edge.
  - Out-of-range digits clamp: ld_dm or ld_ds >5 become 5; ld_um or ld_us >9 become 9.
- ld in RUN: ignored.
- ld and ctrl on the same edge: in non-RUN states, ld wins and ctrl is ignored. In RUN, ctrl acts.
- IDLE + ctrl:
  - Count != 00:00: go to RUN and clear the prescaler.
  - Count == 00:00: stay in IDLE.
- RUN + ctrl: go to PAUSE; the prescaler value is held.
- PAUSE + ctrl: go to RUN; the prescaler resumes from its held value.
- DONE + ctrl: go to IDLE; the count stays at 00:00.
- Prescaler:
  - Counts only in RUN.
  - At CLK_DIV-1 it wraps to 0 and a decrement fires on that edge.
  - First decrement occurs CLK_DIV cycles after the edge that entered RUN.
- Decrement is a BCD borrow chain:
  - us: if 0 then 9 with borrow, else us-1.
  - ds decrements only on borrow from us: if 0 then 5 with borrow, else ds-1.
  - um decrements only on borrow from ds: if 0 then 9 with borrow, else um-1.
  - dm decrements only on borrow from um: dm-1.
- Underflow below 00:00 is impossible: the decrement from 00:01 lands on 00:00 and state=DONE on that same edge. done and 00:00 become visible together.
- ctrl arriving on the edge where the count reaches 00:00: DONE takes priority and ctrl is ignored.
- Count 59:59 is the maximum; after ld it decrements normally to 59:58.
- Reset mid-RUN aborts with no completion flag.

Optional Feature:
- Macro ALARM_EN.
- Defined: adds output port `alarm`. It asserts on the edge entering DONE and stays high for exactly ALARM_LEN clk cycles, using an internal counter.
  - ld, ctrl or rst during the pulse clears `alarm` on that edge (rst immediately).
- Undefined: no `alarm` port and no alarm counter; all other behaviour is identical.

Test Plan:
1. CLK_DIV=1, ld 00:03, then ctrl pulse.
   - running=1; count goes 00:02, 00:01, 00:00 on the next 3 edges.
   - done=1 together with 00:00; running=0.
2. CLK_DIV=1, ld 01:00, ctrl, 1 cycle.
   - Count reads 00:59 (borrow across all digits).
   - Load 10:00: one decrement gives 09:59.
3. CLK_DIV=4, ld 00:10, ctrl, then after 6 cycles ctrl (pause), hold 10 cycles, ctrl.
   - Count 00:09 during the pause.
   - Next decrement to 00:08 occurs 2 cycles after resume.
4. ld with ld_dm=7, ld_um=12, ld_ds=9, ld_us=15 -> count 59:59.
   - ctrl with ld=00:00 in IDLE -> stays IDLE, running=0.
5. RUN at 00:05, assert ld=30:00 -> ignored, count keeps decrementing.
   - Assert rst asynchronously mid-cycle -> all outputs 0 before the next edge.
6. ALARM_EN, ALARM_LEN=3, ld 00:01, ctrl.
   - alarm high exactly 3 cycles starting at the DONE edge.
   - Repeat with ctrl on the 2nd alarm cycle -> alarm drops on that edge; state=IDLE.

Source files
------------

// File: rtl/crono59m_down.sv
// MM:SS BCD count-down timer. Load, start/pause on ctrl, stop and flag done at 00:00.
// Optional `alarm` pulse output is compiled in when the ALARM_EN macro is defined.
`timescale 1ns/1ps

module crono59m_down #(
  parameter int CLK_DIV   = 1,
  parameter int ALARM_LEN = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ld,
  input  logic [3:0] ld_dm,
  input  logic [3:0] ld_um,
  input  logic [3:0] ld_ds,
  input  logic [3:0] ld_us,
  input  logic       ctrl,
  output logic [3:0] dm,
  output logic [3:0] um,
  output logic [3:0] ds,
  output logic [3:0] us,
  output logic       running,
  output logic       done
`ifdef ALARM_EN
  ,
  output logic       alarm
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  localparam int PW = 25;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

  state_t          state_reg;
  logic [PW-1:0]   presc_reg;

  // Load digits indexed us, ds, um, dm; tens digits saturate at 5, units at 9.
  logic [3:0] ld_raw     [4];
  logic [3:0] ld_clamped [4];

  assign ld_raw[0] = ld_us;
  assign ld_raw[1] = ld_ds;
  assign ld_raw[2] = ld_um;
  assign ld_raw[3] = ld_dm;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_clamp
      localparam logic [3:0] LIM = ((gi % 2) == 0) ? 4'd9 : 4'd5;
      assign ld_clamped[gi] = (ld_raw[gi] > LIM) ? LIM : ld_raw[gi];
    end
  endgenerate

  logic [3:0] us_next, ds_next, um_next, dm_next;
  logic       count_zero, count_one, presc_wrap, hit_zero;

  // BCD borrow chain for one-second decrement.
  always_comb begin
    us_next = us - 4'd1;
    ds_next = ds;
    um_next = um;
    dm_next = dm;
    if (us == 4'd0) begin
      us_next = 4'd9;
      if (ds == 4'd0) begin
        ds_next = 4'd5;
        if (um == 4'd0) begin
          um_next = 4'd9;
          dm_next = dm - 4'd1;
        end else begin
          um_next = um - 4'd1;
        end
      end else begin
        ds_next = ds - 4'd1;
      end
    end
  end

  assign count_zero = ({dm, um, ds, us} == 16'h0000);
  assign count_one  = ({dm, um, ds, us} == 16'h0001);
  assign presc_wrap = (presc_reg == PRESC_MAX);
  assign hit_zero   = (state_reg == RUN) && presc_wrap && count_one;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      presc_reg <= '0;
      dm        <= 4'd0;
      um        <= 4'd0;
      ds        <= 4'd0;
      us        <= 4'd0;
      running   <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state_reg)
        RUN: begin
          if (presc_wrap) begin
            presc_reg <= '0;
            dm        <= dm_next;
            um        <= um_next;
            ds        <= ds_next;
            us        <= us_next;
          end else begin
            presc_reg <= presc_reg + 1'b1;
          end
          // Reaching 00:00 outranks a simultaneous pause request.
          if (hit_zero) begin
            state_reg <= DONE;
            running   <= 1'b0;
            done      <= 1'b1;
          end else if (ctrl) begin
            state_reg <= PAUSE;
            running   <= 1'b0;
          end
        end
        default: begin
          if (ld) begin
            state_reg <= IDLE;
            presc_reg <= '0;
            dm        <= ld_clamped[3];
            um        <= ld_clamped[2];
            ds        <= ld_clamped[1];
            us        <= ld_clamped[0];
            running   <= 1'b0;
            done      <= 1'b0;
          end else if (ctrl) begin
            case (state_reg)
              IDLE: begin
                if (!count_zero) begin
                  state_reg <= RUN;
                  presc_reg <= '0;
                  running   <= 1'b1;
                end
              end
              PAUSE: begin
                state_reg <= RUN;
                running   <= 1'b1;
              end
              default: begin
                state_reg <= IDLE;
                done      <= 1'b0;
              end
            endcase
          end
        end
      endcase
    end
  end

`ifdef ALARM_EN
  localparam int AW = (ALARM_LEN > 1) ? $clog2(ALARM_LEN) : 1;

  logic [AW-1:0] alarm_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alarm         <= 1'b0;
      alarm_cnt_reg <= '0;
    end else if (hit_zero) begin
      alarm         <= 1'b1;
      alarm_cnt_reg <= AW'(ALARM_LEN - 1);
    end else if (alarm) begin
      if (ld || ctrl || (alarm_cnt_reg == '0)) begin
        alarm <= 1'b0;
      end else begin
        alarm_cnt_reg <= alarm_cnt_reg - 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_crono59m_down.sv
// Scoreboard bench for crono59m_down: two instances (CLK_DIV 1 and 4) driven alike,
// checked against a seconds-based reference model.
`timescale 1ns/1ps

module tb_crono59m_down;

  localparam int ALEN   = 3;
  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_PAUS = 2;
  localparam int S_DONE = 3;
`ifdef ALARM_EN
  localparam bit HAS_ALARM = 1'b1;
`else
  localparam bit HAS_ALARM = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] dm;
    logic [3:0] um;
    logic [3:0] ds;
    logic [3:0] us;
    logic       running;
    logic       done;
    logic       alarm;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ld = 1'b0;
  logic       ctrl = 1'b0;
  logic [3:0] ld_dm = 4'd0, ld_um = 4'd0, ld_ds = 4'd0, ld_us = 4'd0;

  logic [3:0] dm_o [2];
  logic [3:0] um_o [2];
  logic [3:0] ds_o [2];
  logic [3:0] us_o [2];
  logic       running_o [2];
  logic       done_o [2];
  logic       alarm_o [2];

  int total = 0;
  int bad   = 0;

  exp_t q0[$];
  exp_t q1[$];

  int m_st    [2];
  int m_secs  [2];
  int m_ticks [2];
  int m_alarm [2];
  int divs    [2];

  always #5 clk = ~clk;

  crono59m_down #(.CLK_DIV(1), .ALARM_LEN(ALEN)) dut0 (
    .clk(clk), .rst(rst), .ld(ld), .ld_dm(ld_dm), .ld_um(ld_um), .ld_ds(ld_ds), .ld_us(ld_us),
    .ctrl(ctrl), .dm(dm_o[0]), .um(um_o[0]), .ds(ds_o[0]), .us(us_o[0]),
    .running(running_o[0]), .done(done_o[0])
`ifdef ALARM_EN
    , .alarm(alarm_o[0])
`endif
  );

  crono59m_down #(.CLK_DIV(4), .ALARM_LEN(ALEN)) dut1 (
    .clk(clk), .rst(rst), .ld(ld), .ld_dm(ld_dm), .ld_um(ld_um), .ld_ds(ld_ds), .ld_us(ld_us),
    .ctrl(ctrl), .dm(dm_o[1]), .um(um_o[1]), .ds(ds_o[1]), .us(us_o[1]),
    .running(running_o[1]), .done(done_o[1])
`ifdef ALARM_EN
    , .alarm(alarm_o[1])
`endif
  );

`ifndef ALARM_EN
  assign alarm_o[0] = 1'b0;
  assign alarm_o[1] = 1'b0;
`endif

  function automatic int clampv(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  function automatic exp_t model_out(input int i);
    exp_t e;
    int mm, ss;
    mm = m_secs[i] / 60;
    ss = m_secs[i] % 60;
    e.dm      = 4'(mm / 10);
    e.um      = 4'(mm % 10);
    e.ds      = 4'(ss / 10);
    e.us      = 4'(ss % 10);
    e.running = (m_st[i] == S_RUN);
    e.done    = (m_st[i] == S_DONE);
    e.alarm   = HAS_ALARM && (m_alarm[i] > 0);
    return e;
  endfunction

  function automatic exp_t actual(input int i);
    exp_t a;
    a.dm = dm_o[i]; a.um = um_o[i]; a.ds = ds_o[i]; a.us = us_o[i];
    a.running = running_o[i]; a.done = done_o[i]; a.alarm = alarm_o[i];
    return a;
  endfunction

  function automatic void model_reset(input int i);
    m_st[i] = S_IDLE; m_secs[i] = 0; m_ticks[i] = 0; m_alarm[i] = 0;
  endfunction

  // One clock edge of the reference timer: seconds as a plain integer.
  function automatic void model_step(input int i, input bit l, input bit c, input int ld_secs);
    if (m_alarm[i] > 0) begin
      if (l || c) m_alarm[i] = 0;
      else m_alarm[i] = m_alarm[i] - 1;
    end
    if (m_st[i] == S_RUN) begin
      m_ticks[i] = m_ticks[i] + 1;
      if (m_ticks[i] == divs[i]) begin
        m_ticks[i] = 0;
        m_secs[i]  = m_secs[i] - 1;
        if (m_secs[i] == 0) begin
          m_st[i]    = S_DONE;
          m_alarm[i] = ALEN;
          return;
        end
      end
      if (c) m_st[i] = S_PAUS;
    end else if (l) begin
      m_secs[i]  = ld_secs;
      m_ticks[i] = 0;
      m_st[i]    = S_IDLE;
    end else if (c) begin
      if (m_st[i] == S_IDLE) begin
        if (m_secs[i] != 0) begin
          m_st[i]    = S_RUN;
          m_ticks[i] = 0;
        end
      end else if (m_st[i] == S_PAUS) begin
        m_st[i] = S_RUN;
      end else begin
        m_st[i] = S_IDLE;
      end
    end
  endfunction

  function automatic void show(input string tag, input int i, input exp_t a, input exp_t e);
    $display("FAIL %s dut%0d t=%0t got %0d%0d:%0d%0d run=%0b done=%0b alarm=%0b want %0d%0d:%0d%0d run=%0b done=%0b alarm=%0b",
             tag, i, $time, a.dm, a.um, a.ds, a.us, a.running, a.done, a.alarm,
             e.dm, e.um, e.ds, e.us, e.running, e.done, e.alarm);
  endfunction

  // Monitor: one expected response per clock edge, compared at the falling edge.
  always @(negedge clk) begin
    exp_t e, a;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      a = actual(0);
      total++;
      if (a !== e) begin bad++; show("sb_out", 0, a, e); end
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      a = actual(1);
      total++;
      if (a !== e) begin bad++; show("sb_out", 1, a, e); end
    end
  end

  task automatic cyc(input bit l, input bit c, input int a, input int b, input int cc, input int d);
    int secs;
    @(negedge clk);
    rst = 1'b0;
    ld = l; ctrl = c;
    ld_dm = 4'(a); ld_um = 4'(b); ld_ds = 4'(cc); ld_us = 4'(d);
    secs = (10 * clampv(a, 5) + clampv(b, 9)) * 60 + 10 * clampv(cc, 5) + clampv(d, 9);
    if (l || c) $display("txn t=%0t ld=%0b ctrl=%0b val=%0d:%0d:%0d:%0d", $time, l, c, a, b, cc, d);
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_step(i, l, c, secs);
    q0.push_back(model_out(0));
    q1.push_back(model_out(1));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 0, 0, 0, 0);
  endtask

  // Reset asserted mid-cycle: outputs must clear before the next clock edge.
  task automatic async_reset();
    exp_t z, a;
    z = '0;
    @(negedge clk);
    ld = 1'b0; ctrl = 1'b0;
    #2 rst = 1'b1;
    #1;
    $display("txn t=%0t rst", $time);
    for (int i = 0; i < 2; i++) begin
      a = actual(i);
      total++;
      if (a !== z) begin bad++; show("async_rst", i, a, z); end
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_reset(i);
    q0.push_back(model_out(0));
    q1.push_back(model_out(1));
  endtask

  initial begin
    int r, a, b, c, d;
    bit l, k;
    divs[0] = 1;
    divs[1] = 4;
    for (int i = 0; i < 2; i++) model_reset(i);

    async_reset();

    // Short countdown to done.
    cyc(1, 0, 0, 0, 0, 3);
    cyc(0, 1, 0, 0, 0, 0);
    idle(14);

    // Full borrow chain 01:00 -> 00:59, then 10:00 -> 09:59.
    cyc(1, 0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    idle(2);
    cyc(1, 0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    idle(2);

    // Clamped load, start, pause; then a zero load cannot start.
    cyc(1, 0, 7, 12, 9, 15);
    idle(1);
    cyc(0, 1, 0, 0, 0, 0);
    idle(4);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    idle(2);

    // Pause and resume keeps the prescaler phase.
    cyc(1, 0, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 0, 0);
    idle(5);
    cyc(0, 1, 0, 0, 0, 0);
    idle(10);
    cyc(0, 1, 0, 0, 0, 0);
    idle(6);

    // Load ignored while running; async reset aborts.
    async_reset();
    cyc(1, 0, 0, 0, 0, 5);
    cyc(0, 1, 0, 0, 0, 0);
    idle(1);
    cyc(1, 0, 3, 0, 0, 0);
    idle(2);
    async_reset();

    // Done/alarm, then ctrl during the alarm pulse.
    cyc(1, 0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 0);
    idle(8);
    cyc(1, 0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 0);
    idle(1);
    cyc(0, 1, 0, 0, 0, 0);
    idle(5);
    cyc(1, 0, 0, 0, 0, 2);
    cyc(0, 1, 0, 0, 0, 0);
    idle(8);
    cyc(1, 0, 0, 0, 0, 0);
    idle(2);

    // Randomized traffic.
    for (int n = 0; n < 2500; n++) begin
      r = int'($urandom_range(0, 127));
      if (r == 0) begin
        async_reset();
      end else begin
        l = (r < 8);
        k = ((r % 9) == 1);
        if ($urandom_range(0, 3) != 0) begin
          a = 0; b = 0;
          c = int'($urandom_range(0, 2));
          d = int'($urandom_range(0, 15));
        end else begin
          a = int'($urandom_range(0, 15));
          b = int'($urandom_range(0, 15));
          c = int'($urandom_range(0, 15));
          d = int'($urandom_range(0, 15));
        end
        cyc(l, k, a, b, c, d);
      end
    end

    @(negedge clk);
    #1;
    total++;
    if (q0.size() != 0 || q1.size() != 0) begin
      bad++;
      $display("FAIL sb_drain left=%0d,%0d want 0,0", q0.size(), q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
